// File: rtl/mdu_seq_pkg.sv
// Shared RV32M decode constants, sequencer state encoding and iteration counts.
// MDU_RADIX4_MUL_EN halves the multiply iteration count (2 multiplier bits per cycle).
package mdu_seq_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DIV_ITER = 32;
`ifdef MDU_RADIX4_MUL_EN
  localparam int MDU_ITER = 16;
`else
  localparam int MDU_ITER = 32;
`endif

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational, no latency, no flow control.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH+1:0] trial;
  logic             unused_trial_bit;

  // rem < divisor on entry, so the restored value and a kept difference both fit in WIDTH bits
  always_comb begin
    trial    = {1'b0, rem, dbit} - {2'b00, divisor};
    qbit     = ~trial[WIDTH+1];
    rem_next = qbit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dbit};
  end

  assign unused_trial_bit = trial[WIDTH];

endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide for EX: valid pulse 33 cycles after start (17 for multiply with MDU_RADIX4_MUL_EN),
// divide-by-zero/overflow after 1; holds the pipeline with stallreq while busy, cancel_i aborts in any state.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       func3_i,
  input  logic [WIDTH-1:0] reg1_i,
  input  logic [WIDTH-1:0] reg2_i,
  input  logic [4:0]       wd_i,
  input  logic             cancel_i,
  output logic [WIDTH-1:0] result_o,
  output logic [4:0]       wd_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             stallreq
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state;
  logic [5:0]         cnt;
  logic [2:0]         func3_q;
  logic               neg_res;
  logic               neg_rem;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic               rs1_sgn, rs2_sgn, sign1, sign2;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   mag1, mag2, spec_res;

  always_comb begin
    unique case (func3_i)
      FUNCT3_MUL, FUNCT3_MULH, FUNCT3_DIV, FUNCT3_REM: {rs1_sgn, rs2_sgn} = 2'b11;
      FUNCT3_MULHSU:                                   {rs1_sgn, rs2_sgn} = 2'b10;
      default:                                         {rs1_sgn, rs2_sgn} = 2'b00;
    endcase
    sign1    = rs1_sgn & reg1_i[WIDTH-1];
    sign2    = rs2_sgn & reg2_i[WIDTH-1];
    mag1     = sign1 ? -reg1_i : reg1_i;
    mag2     = sign2 ? -reg2_i : reg2_i;
    div_zero = (reg2_i == '0);
    div_ovf  = ~func3_i[0] & (reg1_i == MIN_NEG) & (reg2_i == '1);
    if (div_zero)
      spec_res = func3_i[1] ? reg1_i : '1;
    else
      spec_res = func3_i[1] ? '0 : MIN_NEG;
  end

  logic [WIDTH-1:0] rem_nx;
  logic             qbit;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc[2*WIDTH-1:WIDTH]),
    .dbit     (acc[WIDTH-1]),
    .divisor  (opnd),
    .rem_next (rem_nx),
    .qbit     (qbit)
  );

  logic [2*WIDTH-1:0] acc_nx;
`ifdef MDU_RADIX4_MUL_EN
  logic [WIDTH+1:0]   addend, msum;
`else
  logic [WIDTH:0]     msum;
`endif

  // Accumulator holds product-high:multiplier for MUL and remainder:dividend/quotient for DIV
  always_comb begin
    acc_nx = acc;
`ifdef MDU_RADIX4_MUL_EN
    case (acc[1:0])
      2'd0:    addend = '0;
      2'd1:    addend = {2'b00, opnd};
      2'd2:    addend = {1'b0, opnd, 1'b0};
      default: addend = {2'b00, opnd} + {1'b0, opnd, 1'b0};
    endcase
    msum = {2'b00, acc[2*WIDTH-1:WIDTH]} + addend;
    if (state == ST_MUL)
      acc_nx = {msum, acc[WIDTH-1:2]};
`else
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    if (state == ST_MUL)
      acc_nx = {msum, acc[WIDTH-1:1]};
`endif
    else if (state == ST_DIV)
      acc_nx = {rem_nx, acc[WIDTH-2:0], qbit};
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, remd, fin_res;
  logic               last;

  always_comb begin
    prod = neg_res ? -acc_nx : acc_nx;
    quo  = neg_res ? -(acc_nx[WIDTH-1:0]) : acc_nx[WIDTH-1:0];
    remd = neg_rem ? -(acc_nx[2*WIDTH-1:WIDTH]) : acc_nx[2*WIDTH-1:WIDTH];
    if (!func3_q[2])
      fin_res = (func3_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    else
      fin_res = func3_q[1] ? remd : quo;
    last = (state == ST_MUL) ? (cnt == 6'(MDU_ITER - 1)) : (cnt == 6'(DIV_ITER - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      func3_q  <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      result_o <= '0;
      wd_o     <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (cancel_i) begin
        state    <= ST_IDLE;
        result_o <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_i) begin
              func3_q <= func3_i;
              wd_o    <= wd_i;
              cnt     <= '0;
              neg_res <= sign1 ^ sign2;
              neg_rem <= sign1;
              if (!func3_i[2]) begin
                opnd  <= mag1;
                acc   <= {{WIDTH{1'b0}}, mag2};
                state <= ST_MUL;
              end else begin
                opnd <= mag2;
                acc  <= {{WIDTH{1'b0}}, mag1};
                if (div_zero || div_ovf) begin
                  result_o <= spec_res;
                  valid_o  <= 1'b1;
                  state    <= ST_DONE;
                end else begin
                  state <= ST_DIV;
                end
              end
            end
          end
          ST_MUL, ST_DIV: begin
            acc <= acc_nx;
            cnt <= cnt + 6'd1;
            if (last) begin
              result_o <= fin_res;
              valid_o  <= 1'b1;
              state    <= ST_DONE;
            end
          end
          default: begin
            state    <= ST_IDLE;
            result_o <= '0;
          end
        endcase
      end
    end
  end

  assign busy_o   = (state != ST_IDLE);
  assign stallreq = ((state == ST_IDLE) & start_i & ~cancel_i) | (state == ST_MUL) | (state == ST_DIV);

endmodule
